// File: rtl/exec_ctrl.sv
// exec_ctrl: issue/writeback controller between decode, an execution unit and the register file.
// Latency: accept edge -> EXEC; next edge captures the result and raises wb_valid_o (2 cycles, 1 instr / 2 cycles peak).
// Backpressure: in_ready_o is 1 in IDLE, follows wb_ready_i in WB, and is 0 in EXEC; the WB result holds until wb_ready_i.
// Ports: clk_i/arst_ni (sync, active-low); in_valid_i/in_ready_o + func_i, rs1/rs2_data_i, imm_i, rd_i (decoded instruction);
//        eu_rs1/rs2/imm/func_o (registered operands to the EU), eu_res_math/gate/shift_i (EU results);
//        wb_valid_o/wb_ready_i, wb_rd_o, wb_data_o (writeback); err_o, busy_o, retired_o (status).

package exec_ctrl_pkg;
  typedef enum logic [3:0] {
    F_AND  = 4'd0,
    F_OR   = 4'd1,
    F_XOR  = 4'd2,
    F_NOT  = 4'd3,
    F_ADD  = 4'd4,
    F_ADDI = 4'd5,
    F_SUB  = 4'd6,
    F_SLL  = 4'd7,
    F_SLLI = 4'd8,
    F_SLR  = 4'd9,
    F_SLRI = 4'd10
  } func_t;
endpackage

module exec_ctrl
  import exec_ctrl_pkg::*;
#(
  parameter int DATAWIDTH = 32,
  parameter int RADDRW    = 5
) (
  input  logic                 clk_i,
  input  logic                 arst_ni,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  func_t                func_i,
  input  logic [DATAWIDTH-1:0] rs1_data_i,
  input  logic [DATAWIDTH-1:0] rs2_data_i,
  input  logic [5:0]           imm_i,
  input  logic [RADDRW-1:0]    rd_i,
  output logic [DATAWIDTH-1:0] eu_rs1_o,
  output logic [DATAWIDTH-1:0] eu_rs2_o,
  output logic [5:0]           eu_imm_o,
  output func_t                eu_func_o,
  input  logic [DATAWIDTH-1:0] eu_res_math_i,
  input  logic [DATAWIDTH-1:0] eu_res_gate_i,
  input  logic [DATAWIDTH-1:0] eu_res_shift_i,
  output logic                 wb_valid_o,
  output logic [RADDRW-1:0]    wb_rd_o,
  output logic [DATAWIDTH-1:0] wb_data_o,
  input  logic                 wb_ready_i,
  output logic                 err_o,
  output logic                 busy_o,
  output logic [15:0]          retired_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t               state_q;
  logic [RADDRW-1:0]    rd_q;
  logic                 func_legal;
  logic                 accept;
  logic                 wb_hs;
  logic [DATAWIDTH-1:0] res_sel;

  // Only the 11 defined codes are executed; anything else is flagged and dropped.
  always_comb begin
    func_legal = 1'b0;
    case (func_i)
      F_AND, F_OR, F_XOR, F_NOT, F_ADD, F_ADDI, F_SUB,
      F_SLL, F_SLLI, F_SLR, F_SLRI: func_legal = 1'b1;
      default:                      func_legal = 1'b0;
    endcase
  end

  // The EU computes all three result classes in parallel; pick the one matching the op in flight.
  always_comb begin
    res_sel = eu_res_math_i;
    case (eu_func_o)
      F_AND, F_OR, F_XOR, F_NOT:      res_sel = eu_res_gate_i;
      F_ADD, F_ADDI, F_SUB:           res_sel = eu_res_math_i;
      F_SLL, F_SLLI, F_SLR, F_SLRI:   res_sel = eu_res_shift_i;
      default:                        res_sel = eu_res_math_i;
    endcase
  end

  // A WB handshake frees the slot on the same edge, so a new instruction can be taken then.
  assign in_ready_o = (state_q == S_IDLE) || ((state_q == S_WB) && wb_ready_i);
  assign busy_o     = (state_q != S_IDLE);
  assign accept     = in_valid_i && in_ready_o;
  assign wb_hs      = (state_q == S_WB) && wb_ready_i;

  always_ff @(posedge clk_i) begin
    if (!arst_ni) begin
      state_q    <= S_IDLE;
      rd_q       <= '0;
      eu_rs1_o   <= '0;
      eu_rs2_o   <= '0;
      eu_imm_o   <= '0;
      eu_func_o  <= F_AND;
      wb_valid_o <= 1'b0;
      wb_rd_o    <= '0;
      wb_data_o  <= '0;
      err_o      <= 1'b0;
      retired_o  <= '0;
    end else begin
      err_o <= 1'b0;

      if (wb_hs) begin
        wb_valid_o <= 1'b0;
        if (retired_o != 16'hFFFF) begin
          retired_o <= retired_o + 16'd1;
        end
        state_q <= S_IDLE;
      end

      if (state_q == S_EXEC) begin
        wb_valid_o <= 1'b1;
        wb_data_o  <= res_sel;
        wb_rd_o    <= rd_q;
        state_q    <= S_WB;
      end

      // Accept can only coincide with IDLE or a WB handshake, so it overrides the IDLE target above.
      if (accept) begin
        eu_rs1_o  <= rs1_data_i;
        eu_rs2_o  <= rs2_data_i;
        eu_imm_o  <= imm_i;
        eu_func_o <= func_i;
        rd_q      <= rd_i;
        if (func_legal) begin
          state_q <= S_EXEC;
        end else begin
          err_o   <= 1'b1;
          state_q <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 32, width of operands and results.
REQ-002 SHALL have parameter RADDRW, default 5, width of destination register index.
REQ-003 SHALL have port clk_i, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port arst_ni, input, 1, reset: synchronous and active-low.
REQ-005 SHALL have port in_valid_i, input, 1, decoded instruction valid.
REQ-006 SHALL have port in_ready_o, output, 1, controller accepts instruction.
REQ-007 SHALL have port func_i, input, func_t, operation code.
REQ-008 SHALL have ports rs1_data_i and rs2_data_i, input, DATAWIDTH, source operands.
REQ-009 SHALL have ports imm_i, input, 6, immediate; and rd_i, input, RADDRW, destination index.
REQ-010 SHALL have ports eu_rs1_o, eu_rs2_o (DATAWIDTH), eu_imm_o (6), eu_func_o (func_t), all outputs, registered operands driven to the execution unit.
REQ-011 SHALL have ports eu_res_math_i, eu_res_gate_i, eu_res_shift_i, input, DATAWIDTH, execution-unit results.
REQ-012 SHALL have ports wb_valid_o (1), wb_rd_o (RADDRW), wb_data_o (DATAWIDTH), outputs, writeback request; wb_ready_i, input, 1, register file accepts.
REQ-013 SHALL have ports err_o, output, 1, illegal-func pulse; busy_o, output, 1, state not IDLE; retired_o, output, 16, retired-instruction count.

Function
REQ-014 SHALL implement FSM states IDLE, EXEC, WB.
REQ-015 in_ready_o SHALL be 1 in IDLE, equal wb_ready_i in WB, and 0 in EXEC.
REQ-016 Accept occurs on in_valid_i & in_ready_o at a rising edge; func, operands, imm and rd SHALL be registered onto eu_* outputs and a rd holding register, and the FSM SHALL enter EXEC.
REQ-017 Accepted legal func in EXEC: next edge SHALL capture the selected result into wb_data_o, set wb_valid_o=1, and enter WB; accept-to-wb_valid_o latency is 2 cycles.
REQ-018 Result select: AND/OR/XOR/NOT -> eu_res_gate_i; ADD/ADDI/SUB -> eu_res_math_i; SLL/SLLI/SLR/SLRI -> eu_res_shift_i.
REQ-019 Accepted func outside the 11 legal codes: no EXEC or WB; err_o SHALL pulse 1 for exactly the cycle after accept, the FSM SHALL stay in or return to IDLE, and retired_o SHALL NOT change.
REQ-020 In WB, wb_valid_o, wb_rd_o and wb_data_o SHALL hold stable until wb_ready_i=1 at an edge.
REQ-021 On WB handshake, retired_o SHALL increment by 1, saturating at 0xFFFF.
REQ-022 On WB handshake, the FSM SHALL go to EXEC if an instruction is accepted on the same edge, else to IDLE; wb_valid_o SHALL drop unless a new result arrives.
REQ-023 Back-to-back throughput SHALL be one instruction per 2 cycles with wb_ready_i held at 1.
REQ-024 rd_i=0 SHALL still execute and write back with wb_rd_o=0; suppressing that write is the register file's job.
REQ-025 eu_* outputs SHALL hold the last accepted values while the FSM is in IDLE.
REQ-026 busy_o SHALL be 0 only in IDLE.

Reset
REQ-027 When arst_ni=0 at an edge, the FSM SHALL enter IDLE and clear all outputs: wb_valid_o=0, wb_data_o=0, wb_rd_o=0, err_o=0, retired_o=0, eu_rs1_o=0, eu_rs2_o=0, eu_imm_o=0, eu_func_o=AND; in_ready_o=1 after release.
REQ-028 Reset in EXEC or WB SHALL discard the in-flight instruction without writeback or count.
REQ-029 in_valid_i SHALL be ignored in any cycle where arst_ni=0.

Verification
REQ-030 ADD, rs1=5, rs2=7, rd=3, wb_ready_i=1: wb_valid_o=1 two cycles after accept, wb_data_o=12, wb_rd_o=3, retired_o=1.
REQ-031 SLLI, rs1=1, imm=4, rd=9, wb_ready_i=0 for 5 cycles then 1: wb_data_o=16 held stable all 5 cycles, in_ready_o=0 until release, retired_o increments once.
REQ-032 Illegal func code: err_o=1 for one cycle, wb_valid_o stays 0, retired_o unchanged, in_ready_o=1 the next cycle.
REQ-033 Back-to-back AND then SUB (rs1=0xF0F0, rs2=0x0FF0) with wb_ready_i=1: second accept on the first WB edge; results 0x00F0 then 0xE100; 2-cycle spacing.
REQ-034 Reset asserted during WB with wb_data_o pending: next cycle wb_valid_o=0, retired_o=0, FSM in IDLE, busy_o=0.
REQ-035 Preload retired_o to 0xFFFF by running 65535 instructions, then one more: retired_o stays 0xFFFF.
